// File: rtl/bcd_down_timer_pkg.sv
// Shared constants for the BCD countdown timer: FSM state codes, digit width
// and the saturating digit clamp used by every decade on load.
package bcd_down_timer_pkg;

  localparam int         DIGIT_W = 4;
  localparam logic [3:0] BCD_MAX = 4'd9;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  function automatic logic [DIGIT_W-1:0] bcd_sat(input logic [DIGIT_W-1:0] d);
    return (d > BCD_MAX) ? BCD_MAX : d;
  endfunction

endpackage

// File: rtl/bcd_down_timer_if.sv
// Command/status bundle between the timer controller and the countdown block.
interface bcd_down_timer_if #(parameter int DIGITS = 4);

  logic                  ce;
  logic                  ld;
  logic [4*DIGITS-1:0]   d;
  logic                  start;
  logic                  stop;
  logic [4*DIGITS-1:0]   q;
  logic                  run;
  logic                  done;
  logic                  tc;

  modport master (output ce, ld, d, start, stop, input q, run, done, tc);
  modport slave  (input ce, ld, d, start, stop, output q, run, done, tc);

endinterface

// File: rtl/bcd_down_timer_mod10dcnt.sv
// Single BCD decade down-counter with saturating load and borrow-out.
module mod10dcnt
  import bcd_down_timer_pkg::*;
(
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_ld,
  input  logic [DIGIT_W-1:0] i_d,
  input  logic               i_bi,
  output logic [DIGIT_W-1:0] o_q,
  output logic               o_bo
);

  logic [DIGIT_W-1:0] r_q;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_q <= '0;
    end else if (i_ld) begin
      r_q <= bcd_sat(i_d);
    end else if (i_bi) begin
      r_q <= (r_q == '0) ? BCD_MAX : (r_q - 4'd1);
    end
  end

  assign o_q  = r_q;
  assign o_bo = i_bi & (r_q == '0);

endmodule

// File: rtl/bcd_down_timer.sv
// Multi-digit BCD countdown timer: decade chain plus IDLE/RUN/DONE control,
// with a combinational terminal-count strobe on the final decrement.
module bcd_down_timer
  import bcd_down_timer_pkg::*;
#(
  parameter int DIGITS = 4
)(
  input  logic                i_clk,
  input  logic                i_rst,
  bcd_down_timer_if.slave     bus
);

  logic [1:0]          r_state;
  logic [1:0]          w_next;
  logic [DIGITS:0]     w_borrow;
  logic [4*DIGITS-1:0] w_q;
  logic                w_zero;
  logic                w_one;
  logic                w_unused;

  assign w_borrow[0] = (r_state == ST_RUN) & bus.ce & ~bus.stop & ~bus.ld;

  for (genvar g = 0; g < DIGITS; g++) begin : g_digit
    mod10dcnt u_dig (
      .i_clk (i_clk),
      .i_rst (i_rst),
      .i_ld  (bus.ld),
      .i_d   (bus.d[g*DIGIT_W +: DIGIT_W]),
      .i_bi  (w_borrow[g]),
      .o_q   (w_q[g*DIGIT_W +: DIGIT_W]),
      .o_bo  (w_borrow[g+1])
    );
  end

  // The top decade's borrow can only fire on underflow, which the FSM prevents.
  assign w_unused = w_borrow[DIGITS];

  assign w_zero = (w_q == '0);
  assign w_one  = (w_q == {{(4*DIGITS-1){1'b0}}, 1'b1});

  always_comb begin
    w_next = r_state;
    if (bus.ld) begin
      w_next = ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE: if (!bus.stop && bus.start && !w_zero) w_next = ST_RUN;
        ST_RUN: begin
          if (bus.stop)              w_next = ST_IDLE;
          else if (bus.ce && w_one)  w_next = ST_DONE;
        end
        ST_DONE: w_next = ST_DONE;
        default: w_next = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) r_state <= ST_IDLE;
    else       r_state <= w_next;
  end

  assign bus.q    = w_q;
  assign bus.run  = (r_state == ST_RUN);
  assign bus.done = (r_state == ST_DONE);
  assign bus.tc   = (r_state == ST_RUN) & bus.ce & ~bus.ld & ~bus.stop & w_one;

endmodule

// File: doc/bcd_down_timer.md
# bcd_down_timer

Cascadable multi-digit BCD countdown timer for the lab-board timer/stopwatch datapath. It counts a loaded BCD value down toward zero, one step per qualified tick. It is the decrementing counterpart of the existing decade up-counter chain and drives the same 7-segment display mux. A run/stop state machine controls it, and it raises DONE when the count reaches zero.

## Interface
Parameters:
- DIGITS, 4, number of BCD decades; Q and D are 4*DIGITS bits wide.

Ports:
- CLK  input  1  system clock; all state changes on the rising edge.
- R  input  1  reset, asynchronous, active-high.
- CE  input  1  count tick (single-cycle pulse from the prescaler); decrements only in RUN.
- LD  input  1  synchronous load of D.
- D  input  4*DIGITS  preset value, BCD, digit 0 in D[3:0].
- START  input  1  begin or resume counting.
- STOP  input  1  pause counting.
- Q  output  4*DIGITS  current count, BCD, digit 0 in Q[3:0].
- RUN  output  1  high while in RUN.
- DONE  output  1  high while in DONE.
- TC  output  1  terminal-count strobe, combinational.

## Operation
- States: IDLE, RUN, DONE. Reset sends the block to IDLE with Q=0, RUN=0 and DONE=0.
- Command priority each cycle is LD > STOP > START > CE.
- LD, from any state:
  - Q <= D, with each digit >9 saturated to 9.
  - Next state IDLE; DONE clears.
  - CE in the same cycle is ignored.
- IDLE:
  - START with Q≠0 moves to RUN.
  - START with Q=0 is ignored; the block stays in IDLE.
  - CE has no effect.
- RUN, on CE:
  - Q decrements by 1 in BCD.
  - A digit at 0 wraps to 9 and borrows from the next digit; a digit at 1–9 decrements and stops the borrow.
- RUN to DONE: on the CE where Q==1, Q becomes 0 and the next state is DONE.
- RUN, STOP: next state IDLE with Q held; no decrement even if CE is also high. A later START resumes from the held Q.
- DONE:
  - Q is held at 0.
  - START, STOP and CE are all ignored.
  - Only LD or R leaves DONE.
- TC = RUN & CE & ~LD & ~STOP & (Q==1). TC is a one-cycle strobe that coincides with the final decrement and is suitable for chaining or buzzer triggering.
- Q never underflows: the zero state is never decremented.

## Timing
- Q, RUN and DONE are registered and change one edge after the qualifying input is sampled.
- Latency:
  - CE to Q update: 1 cycle.
  - START to RUN=1: 1 cycle.
  - A CE in the same cycle as START is not counted; the first decrement needs a CE with RUN already high.
- TC is combinational from Q, RUN, CE, LD and STOP. It is high in the cycle before DONE rises.
- R asserted mid-count forces Q=0, RUN=0 and DONE=0 immediately, without waiting for CLK. After R deasserts, the block is in IDLE and needs LD and START to run again.
- No combinational path runs from D to any output.

## Structure
- Shared package:
  - State encoding constants for IDLE, RUN and DONE.
  - BCD_MAX = 4'd9.
  - A digit-width constant of 4.
- Sub-module mod10dcnt: a single decade down-counter.
  - Ports: CLK, R, LD, D[3:0], BI (borrow-in/enable), Q[3:0], BO.
  - BO = BI & (Q==0).
  - Saturating load.
- The top instantiates DIGITS copies of mod10dcnt.
  - Digit 0 gets BI = RUN & CE & ~STOP & ~LD.
  - Digit k gets BI = BO of digit k-1.
- Zero detect and the FSM live in the top.

## Test plan
- Reset: assert R mid-RUN with Q=0357 → Q=0000, RUN=0 and DONE=0 with no clock edge; after release, START is ignored (Q=0).
- Borrow chain: LD D=0102, START, 3 CE pulses → Q sequence 0101, 0100, 0099; RUN stays 1.
- Terminal: LD D=0002, START, 2 CEs.
  - TC=1 only during the second CE cycle.
  - Next edge: Q=0000, DONE=1, RUN=0.
  - Further CE and START leave Q and DONE unchanged.
- Stop/resume: in RUN at Q=0050, STOP together with CE → Q stays 0050 and the state goes to IDLE; START, then 1 CE → Q=0049.
- Priority and saturation:
  - LD D=0x00A3 together with CE while in RUN → Q=0093, state IDLE, no decrement.
  - LD while in DONE → DONE=0.
